rfblackwidow_ic_refill: RTL

RFBLACKWIDOW_IC_REFILL -- requirements
Module: rfBlackWidow_ic_refill

---
 rtl/rfblackwidow_ic_refill.sv | 82 ++++++++
 1 files changed

// File: rtl/rfblackwidow_ic_refill.sv
// rfblackwidow_ic_refill: I-cache line refill FSM that fetches 4x128-bit beats, then writes tag and data RAMs.
// Ports: miss/miss_adr are the fetch miss request. req_o/req_adr/req_ack_i form the memory read request.
// resp_* carry the beat responses. tag_wr/tag_ipo/tag_way/line_wr/line_o drive the RAM writes.
// busy/done/err report status.
module rfblackwidow_ic_refill #(
  parameter int AWID  = 32,
  parameter int BEATS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 miss,
  input  logic [AWID-1:0]      miss_adr,
  output logic                 req_o,
  output logic [AWID-1:0]      req_adr,
  input  logic                 req_ack_i,
  input  logic                 resp_valid_i,
  input  logic [127:0]         resp_dat_i,
  input  logic                 resp_err_i,
  output logic                 tag_wr,
  output logic [AWID-1:0]      tag_ipo,
  output logic [1:0]           tag_way,
  output logic                 line_wr,
  output logic [128*BEATS-1:0] line_o,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);
  localparam int BW = $clog2(BEATS);
  typedef enum logic [1:0] {IDLE, REQ, FILL, WRITE} state_t;
  state_t state, nxt;
  logic [BW-1:0] beat;
  logic [1:0] victim;
  logic beat_ok, beat_err, req_n, busy_n, wr_n;
  assign beat_ok  = state == FILL && resp_valid_i && !resp_err_i;
  assign beat_err = state == FILL && resp_valid_i && resp_err_i;
  assign tag_way  = victim;
  always_comb
    nxt = state == IDLE ? (miss ? REQ : IDLE) :
          state == REQ  ? (req_ack_i ? FILL : REQ) :
          state == FILL ? (beat_err ? IDLE : (beat_ok && beat == BW'(BEATS-1)) ? WRITE : FILL) :
          IDLE;
  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    req_n  = nxt == REQ;
    busy_n = nxt != IDLE;
    wr_n   = nxt == WRITE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      req_o   <= 1'b0;
      busy    <= 1'b0;
      tag_wr  <= 1'b0;
      line_wr <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      req_adr <= '0;
      tag_ipo <= '0;
      line_o  <= '0;
      beat    <= '0;
      victim  <= '0;
    end else begin
      state   <= nxt;
      req_o   <= req_n;
      busy    <= busy_n;
      tag_wr  <= wr_n;
      line_wr <= wr_n;
      done    <= wr_n;
      err     <= beat_err;
      if (state == IDLE && miss) begin
        req_adr <= miss_adr & ~AWID'(63);
        tag_ipo <= miss_adr & ~AWID'(63);
      end
      if (state == REQ) beat <= '0;
      if (beat_ok) begin
        line_o[128*int'(beat) +: 128] <= resp_dat_i;
        beat <= beat + 1'b1;
      end
      if (state == WRITE) victim <= victim + 1'b1;
    end
  end
endmodule
